// File: rtl/conv_frame_streamer_if.sv
// Pixel stream from the frame reader into the convolution datapath.
// valid/ready: a pixel transfers on each rising edge with pix_valid && pix_ready; while
// pix_valid is high and pix_ready low, data, position and markers hold steady.
interface conv_frame_streamer_if #(
  parameter int PIXEL_WIDTH = 30,
  parameter int X_WIDTH     = 10,
  parameter int Y_WIDTH     = 9
);
  logic                   pix_valid;
  logic                   pix_ready;
  logic [PIXEL_WIDTH-1:0] pix_data;
  logic [X_WIDTH-1:0]     pix_x;
  logic [Y_WIDTH-1:0]     pix_y;
  logic                   pix_sof;
  logic                   pix_eol;
  logic                   pix_eof;

  modport master (
    output pix_valid, pix_data, pix_x, pix_y, pix_sof, pix_eol, pix_eof,
    input  pix_ready
  );

  modport slave (
    input  pix_valid, pix_data, pix_x, pix_y, pix_sof, pix_eol, pix_eof,
    output pix_ready
  );
endinterface

// File: rtl/conv_frame_streamer.sv
// Raster-scan frame reader: issues credit-limited reads to a 1-cycle-latency frame memory
// and presents the pixels through a 2-entry FWFT buffer with position and frame markers.
module conv_frame_streamer #(
  parameter int WIDTH       = 640,
  parameter int HEIGHT      = 480,
  parameter int ADDR_WIDTH  = 19,
  parameter int PIXEL_WIDTH = 30
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  output logic                   mem_rd,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  input  logic [PIXEL_WIDTH-1:0] mem_rdata,
  conv_frame_streamer_if.master  stream,
  output logic                   busy,
  output logic                   done,
  output logic [1:0]             dbg_state
);
  localparam int X_WIDTH = $clog2(WIDTH);
  localparam int Y_WIDTH = $clog2(HEIGHT);
  localparam logic [X_WIDTH-1:0] X_LAST = X_WIDTH'(WIDTH - 1);
  localparam logic [Y_WIDTH-1:0] Y_LAST = Y_WIDTH'(HEIGHT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_DRAIN  = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [X_WIDTH-1:0]     rd_x_q;
  logic [Y_WIDTH-1:0]     rd_y_q;
  logic [ADDR_WIDTH-1:0]  next_addr_q;
  logic [ADDR_WIDTH-1:0]  last_addr_q;
  logic                   inflight_q;
  logic [PIXEL_WIDTH-1:0] fifo_q [2];
  logic                   wr_ptr_q;
  logic                   rd_ptr_q;
  logic [1:0]             count_q;
  logic [X_WIDTH-1:0]     out_x_q;
  logic [Y_WIDTH-1:0]     out_y_q;
  logic                   pop;
  logic                   rd_last;

  assign pop     = stream.pix_valid && stream.pix_ready;
  assign rd_last = (rd_x_q == X_LAST) && (rd_y_q == Y_LAST);

  always_comb begin
    state_d = state_q;
    mem_rd  = 1'b0;
    case (state_q)
      S_IDLE:   if (start) state_d = S_RUN;
      S_RUN: begin
        // Credit: buffered + in-flight words after this cycle's pop must leave a free slot.
        mem_rd = (3'(count_q) + 3'(inflight_q)) < (3'd2 + 3'(pop));
        if (mem_rd && rd_last) state_d = S_DRAIN;
      end
      S_DRAIN:  if (pop && stream.pix_eof) state_d = S_FINISH;
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // The address output shows the last issued address whenever no read is being issued.
  assign mem_addr  = mem_rd ? next_addr_q : last_addr_q;
  assign busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done      = (state_q == S_FINISH);
  assign dbg_state = state_q;

  assign stream.pix_valid = (count_q != 2'd0);
  assign stream.pix_data  = fifo_q[rd_ptr_q];
  assign stream.pix_x     = out_x_q;
  assign stream.pix_y     = out_y_q;
  assign stream.pix_sof   = stream.pix_valid && (out_x_q == '0) && (out_y_q == '0);
  assign stream.pix_eol   = stream.pix_valid && (out_x_q == X_LAST);
  assign stream.pix_eof   = stream.pix_eol && (out_y_q == Y_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rd_x_q      <= '0;
      rd_y_q      <= '0;
      next_addr_q <= '0;
      last_addr_q <= '0;
      inflight_q  <= 1'b0;
      fifo_q[0]   <= '0;
      fifo_q[1]   <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= '0;
      out_x_q     <= '0;
      out_y_q     <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= mem_rd;

      if (state_q == S_IDLE && start) begin
        rd_x_q      <= '0;
        rd_y_q      <= '0;
        next_addr_q <= '0;
        out_x_q     <= '0;
        out_y_q     <= '0;
      end else if (mem_rd) begin
        last_addr_q <= next_addr_q;
        next_addr_q <= next_addr_q + ADDR_WIDTH'(1);
        if (rd_x_q == X_LAST) begin
          rd_x_q <= '0;
          rd_y_q <= rd_last ? '0 : rd_y_q + Y_WIDTH'(1);
        end else begin
          rd_x_q <= rd_x_q + X_WIDTH'(1);
        end
      end

      if (inflight_q) begin
        fifo_q[wr_ptr_q] <= mem_rdata;
        wr_ptr_q         <= ~wr_ptr_q;
      end

      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
        if (out_x_q == X_LAST) begin
          out_x_q <= '0;
          out_y_q <= (out_y_q == Y_LAST) ? '0 : out_y_q + Y_WIDTH'(1);
        end else begin
          out_x_q <= out_x_q + X_WIDTH'(1);
        end
      end

      count_q <= count_q + 2'(inflight_q) - 2'(pop);
    end
  end

  // The read credit guarantees a landing word always finds a free slot.
  fifo_no_overflow: assert property (@(posedge clock) disable iff (reset)
    !(inflight_q && !pop && count_q == 2'd2));
endmodule

// File: tb/tb_conv_frame_streamer.sv
// Bench for conv_frame_streamer on a 4x3 frame: directed scenarios plus random backpressure
// and random frame contents, checked against a raster-order scoreboard and credit model.
module tb_conv_frame_streamer;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int N  = W * H;
  localparam int AW = 4;
  localparam int PW = 30;
  localparam int XW = 2;
  localparam int YW = 2;
  localparam int EW = PW + XW + YW + 3;

  localparam int MODE_ALWAYS = 0;
  localparam int MODE_TOGGLE = 1;
  localparam int MODE_HOLD20 = 2;
  localparam int MODE_RANDOM = 3;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic [PW-1:0] mem_rdata;
  logic          busy;
  logic          done;
  logic [1:0]    dbg_state;

  logic [PW-1:0] mem [16];

  int vec_count = 0;
  int err_count = 0;

  always #5 clock = ~clock;

  conv_frame_streamer_if #(.PIXEL_WIDTH(PW), .X_WIDTH(XW), .Y_WIDTH(YW)) stream ();

  conv_frame_streamer #(
    .WIDTH(W), .HEIGHT(H), .ADDR_WIDTH(AW), .PIXEL_WIDTH(PW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .mem_rd(mem_rd),
    .mem_addr(mem_addr),
    .mem_rdata(mem_rdata),
    .stream(stream),
    .busy(busy),
    .done(done),
    .dbg_state(dbg_state)
  );

  // Frame memory: data valid exactly one cycle after the read strobe, garbage otherwise.
  always @(posedge clock) mem_rdata <= mem_rd ? mem[mem_addr] : PW'($urandom);

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_count++;
    if (got !== exp) begin
      err_count++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [EW-1:0] pix_word(input logic [PW-1:0] d, input int x, input int y);
    logic sof, eol, eof;
    sof = (x == 0) && (y == 0);
    eol = (x == W - 1);
    eof = eol && (y == H - 1);
    return {d, XW'(x), YW'(y), sof, eol, eof};
  endfunction

  // Reference model: a frame is the raster list of memory words; a read may be issued while
  // reads outstanding (issued minus transferred, after this cycle's pop) stay below two, and
  // a read's word becomes visible two cycles after issue.
  logic [EW-1:0] exp_q[$];
  int            issued, xfered, lag;
  bit            m_active, m_done, chk_zero, held;
  logic [EW-1:0] held_word;

  always @(negedge clock) begin
    logic [EW-1:0] cur;
    bit            pop, exp_rd, arm, done_next;
    cur = {stream.pix_data, stream.pix_x, stream.pix_y,
           stream.pix_sof, stream.pix_eol, stream.pix_eof};
    if (reset) begin
      exp_q.delete();
      issued = 0; xfered = 0; lag = 0;
      m_active = 0; m_done = 0; held = 0; chk_zero = 1;
    end else begin
      if (chk_zero) begin
        check_eq("reset_outputs", 64'({mem_rd, mem_addr, stream.pix_valid, cur, busy, done}), 64'(0));
        chk_zero = 0;
      end
      pop = stream.pix_valid && stream.pix_ready;
      check_eq("pix_valid", 64'(stream.pix_valid), 64'((lag - xfered) > 0));
      if (held) check_eq("stall_hold", 64'(cur), 64'(held_word));
      exp_rd = m_active && (issued < N) && ((issued - xfered - int'(pop)) < 2);
      check_eq("mem_rd", 64'(mem_rd), 64'(exp_rd));
      check_eq("busy", 64'(busy), 64'(m_active));
      check_eq("done", 64'(done), 64'(m_done));
      lag = issued;
      if (exp_rd) begin
        if (mem_rd) check_eq("mem_addr", 64'(mem_addr), 64'(issued));
        issued++;
      end
      arm       = start && !m_active && !m_done;
      done_next = 0;
      if (pop) begin
        if (exp_q.size() == 0) check_eq("extra_pixel", 64'(cur), 64'(0));
        else check_eq("pixel", 64'(cur), 64'(exp_q.pop_front()));
        xfered++;
        if (m_active && xfered == N) begin
          m_active  = 0;
          done_next = 1;
        end
      end
      held      = stream.pix_valid && !stream.pix_ready;
      held_word = cur;
      m_done    = done_next;
      if (arm) begin
        m_active = 1;
        issued = 0; xfered = 0; lag = 0;
        exp_q.delete();
        for (int a = 0; a < N; a++) exp_q.push_back(pix_word(mem[a], a % W, a / W));
      end
    end
  end

  function automatic logic ready_for(input int mode, input int cyc);
    case (mode)
      MODE_TOGGLE: return (cyc % 4 == 0) || (cyc % 4 == 3);
      MODE_HOLD20: return cyc > 20;
      MODE_RANDOM: return $urandom_range(0, 3) != 0;
      default:     return 1'b1;
    endcase
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1 start = 1'b0;
    end
  endtask

  // Cycle 0 is the cycle in which start is driven high.
  task automatic run_frame(input int mode, input int restart_at, input int reset_at,
                           input bit start_at_done);
    int cyc;
    bit fin;
    @(posedge clock);
    #1 start = 1'b1;
    stream.pix_ready = ready_for(mode, 0);
    cyc = 0;
    fin = 0;
    while (!fin) begin
      @(posedge clock);
      #1 cyc++;
      start = (cyc == restart_at);
      stream.pix_ready = ready_for(mode, cyc);
      if (cyc == reset_at) begin
        reset = 1'b1;
        start = 1'b1;
      end else if (reset_at >= 0 && cyc == reset_at + 1) begin
        reset = 1'b0;
        fin   = 1;
      end else if (done) begin
        if (start_at_done) start = 1'b1;
        fin = 1;
      end else if (cyc > 400) begin
        check_eq("frame_timeout", 64'(cyc), 64'(0));
        fin = 1;
      end
    end
    idle(3);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    stream.pix_ready = 1'b0;
    for (int a = 0; a < 16; a++) mem[a] = PW'(a);
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    idle(3);

    run_frame(MODE_ALWAYS, -1, -1, 1'b0);
    run_frame(MODE_TOGGLE, -1, -1, 1'b0);
    run_frame(MODE_HOLD20, -1, -1, 1'b0);
    run_frame(MODE_ALWAYS,  5, -1, 1'b0);
    run_frame(MODE_ALWAYS, -1,  6, 1'b0);
    run_frame(MODE_ALWAYS, -1, -1, 1'b1);

    for (int f = 0; f < 20; f++) begin
      for (int a = 0; a < 16; a++) mem[a] = PW'($urandom);
      run_frame(MODE_RANDOM, (f % 4 == 1) ? int'($urandom_range(1, 10)) : -1, -1, f[0]);
    end

    idle(4);
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end
endmodule
